// File: rtl/btn_irq_ctrl_if.sv
// Button/interrupt controller signal bundle: raw button and CPU-side controls in,
// debounced level, request, overrun flag and press count out.
interface btn_irq_ctrl_if #(
    parameter int unsigned CNT_W = 8
);
    logic             btn_i;
    logic             irq_ack_i;
    logic             overrun_clr_i;
    logic             btn_state_o;
    logic             irq_req_o;
    logic             overrun_o;
    logic [CNT_W-1:0] press_cnt_o;

    modport master (
        output btn_i,
        output irq_ack_i,
        output overrun_clr_i,
        input  btn_state_o,
        input  irq_req_o,
        input  overrun_o,
        input  press_cnt_o
    );

    modport slave (
        input  btn_i,
        input  irq_ack_i,
        input  overrun_clr_i,
        output btn_state_o,
        output irq_req_o,
        output overrun_o,
        output press_cnt_o
    );
endinterface

// File: rtl/btn_irq_ctrl.sv
// Push-button debouncer feeding a level interrupt request with acknowledge,
// sticky overrun detection and a wrapping accepted-press counter.
module btn_irq_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    btn_irq_ctrl_if.slave        bus_io
);
    localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DbW-1:0] DbMax = DbW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {StIdle, StPending} state_e;

    logic             sync1_q, sync_q;
    logic [DbW-1:0]   db_cnt_q, db_cnt_d;
    logic             btn_state_q, btn_state_d;
    state_e           state_q, state_d;
    logic             overrun_q, overrun_d;
    logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
    logic             mismatch;
    logic             accept;
    logic             press_evt;
    logic             overrun_set;

    assign mismatch  = sync_q != btn_state_q;
    assign accept    = mismatch && (db_cnt_q == DbMax);
    // Only a rising debounced level counts as a press.
    assign press_evt = accept && sync_q;

    always_comb begin
        db_cnt_d    = '0;
        btn_state_d = btn_state_q;
        if (accept) begin
            btn_state_d = sync_q;
        end else if (mismatch) begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        press_cnt_d = press_cnt_q;
        overrun_set = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (press_evt) begin
                    state_d     = StPending;
                    press_cnt_d = press_cnt_q + 1'b1;
                end
            end
            StPending: begin
                if (press_evt) begin
                    // An ack in the same cycle frees the slot for the new press.
                    if (bus_io.irq_ack_i) begin
                        press_cnt_d = press_cnt_q + 1'b1;
                    end else begin
                        overrun_set = 1'b1;
                    end
                end else if (bus_io.irq_ack_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        overrun_d = overrun_set | (overrun_q & ~bus_io.overrun_clr_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q     <= 1'b0;
            sync_q      <= 1'b0;
            db_cnt_q    <= '0;
            btn_state_q <= 1'b0;
            state_q     <= StIdle;
            overrun_q   <= 1'b0;
            press_cnt_q <= '0;
        end else begin
            sync1_q     <= bus_io.btn_i;
            sync_q      <= sync1_q;
            db_cnt_q    <= db_cnt_d;
            btn_state_q <= btn_state_d;
            state_q     <= state_d;
            overrun_q   <= overrun_d;
            press_cnt_q <= press_cnt_d;
        end
    end

    assign bus_io.btn_state_o = btn_state_q;
    assign bus_io.irq_req_o   = (state_q == StPending);
    assign bus_io.overrun_o   = overrun_q;
    assign bus_io.press_cnt_o = press_cnt_q;
endmodule

// File: tb/tb_btn_irq_ctrl.sv
// Bench for btn_irq_ctrl: directed scenarios plus randomized traffic, all compared
// against a sliding-window reference model of the debounce and request rules.
module tb_btn_irq_ctrl;
    localparam int unsigned D  = 4;
    localparam int unsigned CW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    btn_irq_ctrl_if #(.CNT_W(CW)) bus ();

    btn_irq_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (CW)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_io (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: raw button history (bit 0 newest), accepted level, request,
    // overrun flag and press count.
    logic [D:0]    hist;
    logic          m_state, m_pend, m_ovr;
    logic [CW-1:0] m_cnt;

    function automatic logic [CW+2:0] act();
        return {bus.btn_state_o, bus.irq_req_o, bus.overrun_o, bus.press_cnt_o};
    endfunction

    function automatic logic [CW+2:0] exp_v();
        return {m_state, m_pend, m_ovr, m_cnt};
    endfunction

    // A new level is accepted once the synchronized input (raw delayed by two
    // samples) has disagreed with the accepted level for D consecutive edges.
    task automatic model_edge();
        bit all_diff;
        bit press;
        bit set_ovr;
        if (rst) begin
            hist    = '0;
            m_state = 1'b0;
            m_pend  = 1'b0;
            m_ovr   = 1'b0;
            m_cnt   = '0;
        end else begin
            all_diff = 1'b1;
            for (int i = 1; i <= D; i++) if (hist[i] == m_state) all_diff = 1'b0;
            press = 1'b0;
            if (all_diff) begin
                m_state = ~m_state;
                press   = m_state;
            end
            set_ovr = press && m_pend && !bus.irq_ack_i;
            if (press && (!m_pend || bus.irq_ack_i)) begin
                m_cnt  = m_cnt + 1'b1;
                m_pend = 1'b1;
            end else if (!press && bus.irq_ack_i) begin
                m_pend = 1'b0;
            end
            if (set_ovr) m_ovr = 1'b1;
            else if (bus.overrun_clr_i) m_ovr = 1'b0;
            hist = {hist[D-1:0], bus.btn_i};
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.btn_i = 1'b1;
        bus.irq_ack_i = 1'b0;
        bus.overrun_clr_i = 1'b0;
        ticks(2);
        checks++;
        if (act() !== '0) begin
            errors++;
            $display("FAIL reset_state: got %h want 0", act());
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.irq_req_o !== 1'b0 || bus.btn_state_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_cycle: got irq=%b state=%b want 0 0",
                     bus.irq_req_o, bus.btn_state_o);
        end
        ticks(4);
        checks++;
        if (bus.irq_req_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_held_early: got irq=%b want 0", bus.irq_req_o);
        end
        tick();
        checks++;
        if (act() !== {1'b1, 1'b1, 1'b0, 8'd1} || act() !== exp_v()) begin
            errors++;
            $display("FAIL reset_held_press: got %h want %h", act(), exp_v());
        end
    endtask

    task automatic test_clean_press();
        do_reset();
        bus.btn_i = 1'b0;
        ticks(8);
        bus.btn_i = 1'b1;
        ticks(5);
        checks++;
        if (bus.btn_state_o !== 1'b0 || bus.irq_req_o !== 1'b0) begin
            errors++;
            $display("FAIL press_edge5: got state=%b irq=%b want 0 0",
                     bus.btn_state_o, bus.irq_req_o);
        end
        tick();
        checks++;
        if (act() !== {1'b1, 1'b1, 1'b0, 8'd1} || act() !== exp_v()) begin
            errors++;
            $display("FAIL press_edge6: got %h want %h", act(), exp_v());
        end
    endtask

    task automatic test_glitch();
        do_reset();
        bus.btn_i = 1'b1;
        ticks(3);
        bus.btn_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (act() !== '0 || act() !== exp_v()) begin
                errors++;
                $display("FAIL glitch_cycle%0d: got %h want 0", i, act());
            end
        end
    endtask

    task automatic test_ack();
        bus.btn_i = 1'b1;
        ticks(6);
        bus.irq_ack_i = 1'b1;
        tick();
        bus.irq_ack_i = 1'b0;
        checks++;
        if (bus.irq_req_o !== 1'b0 || act() !== exp_v()) begin
            errors++;
            $display("FAIL ack_clears: got %h want %h", act(), exp_v());
        end
        bus.btn_i = 1'b0;
        ticks(6);
        bus.irq_ack_i = 1'b1;
        tick();
        bus.irq_ack_i = 1'b0;
        checks++;
        if (act() !== {1'b0, 1'b0, 1'b0, 8'd1} || act() !== exp_v()) begin
            errors++;
            $display("FAIL ack_idle_ignored: got %h want %h", act(), exp_v());
        end
        bus.btn_i = 1'b1;
        ticks(6);
        checks++;
        if (act() !== {1'b1, 1'b1, 1'b0, 8'd2} || act() !== exp_v()) begin
            errors++;
            $display("FAIL ack_repress: got %h want %h", act(), exp_v());
        end
    endtask

    task automatic test_overrun();
        bus.btn_i = 1'b0;
        ticks(6);
        bus.btn_i = 1'b1;
        ticks(6);
        checks++;
        if (act() !== {1'b1, 1'b1, 1'b1, 8'd2} || act() !== exp_v()) begin
            errors++;
            $display("FAIL overrun_set: got %h want %h", act(), exp_v());
        end
        bus.overrun_clr_i = 1'b1;
        tick();
        bus.overrun_clr_i = 1'b0;
        checks++;
        if (bus.overrun_o !== 1'b0 || act() !== exp_v()) begin
            errors++;
            $display("FAIL overrun_clr: got %h want %h", act(), exp_v());
        end
        bus.btn_i = 1'b0;
        ticks(6);
        bus.btn_i = 1'b1;
        bus.overrun_clr_i = 1'b1;
        ticks(6);
        bus.overrun_clr_i = 1'b0;
        checks++;
        if (act() !== {1'b1, 1'b1, 1'b1, 8'd2} || act() !== exp_v()) begin
            errors++;
            $display("FAIL overrun_set_wins: got %h want %h", act(), exp_v());
        end
        bus.overrun_clr_i = 1'b1;
        tick();
        bus.overrun_clr_i = 1'b0;
    endtask

    task automatic test_collision();
        bus.btn_i = 1'b0;
        ticks(6);
        bus.btn_i = 1'b1;
        ticks(5);
        bus.irq_ack_i = 1'b1;
        tick();
        bus.irq_ack_i = 1'b0;
        checks++;
        if (act() !== {1'b1, 1'b1, 1'b0, 8'd3} || act() !== exp_v()) begin
            errors++;
            $display("FAIL collision: got %h want %h", act(), exp_v());
        end
        tick();
        checks++;
        if (bus.irq_req_o !== 1'b1 || act() !== exp_v()) begin
            errors++;
            $display("FAIL collision_hold: got %h want %h", act(), exp_v());
        end
    endtask

    task automatic test_wrap_reset();
        do_reset();
        bus.btn_i = 1'b0;
        ticks(3);
        for (int n = 0; n < 256; n++) begin
            bus.btn_i = 1'b1;
            ticks(6);
            bus.irq_ack_i = 1'b1;
            tick();
            bus.irq_ack_i = 1'b0;
            bus.btn_i = 1'b0;
            ticks(6);
        end
        checks++;
        if (bus.press_cnt_o !== 8'd0 || act() !== exp_v()) begin
            errors++;
            $display("FAIL wrap: got %h want %h", act(), exp_v());
        end
        bus.btn_i = 1'b1;
        ticks(6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (act() !== '0 || act() !== exp_v()) begin
            errors++;
            $display("FAIL reset_pending: got %h want 0", act());
        end
        bus.btn_i = 1'b0;
    endtask

    task automatic test_random();
        int hold = 0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                bus.btn_i = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 8);
            end
            hold--;
            bus.irq_ack_i     = ($urandom_range(0, 3) == 0);
            bus.overrun_clr_i = ($urandom_range(0, 7) == 0);
            rst               = ($urandom_range(0, 499) == 0);
            tick();
            checks++;
            if (act() !== exp_v()) begin
                errors++;
                $display("FAIL random_cycle%0d: got %h want %h", i, act(), exp_v());
            end
        end
        rst = 1'b0;
        bus.irq_ack_i = 1'b0;
        bus.overrun_clr_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_ack();
        test_overrun();
        test_collision();
        test_wrap_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/btn_irq_ctrl.md
BTN_IRQ_CTRL -- requirements
Module: btn_irq_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, number of consecutive sampled cycles a new button level must persist before it is accepted; SHALL be >= 2.
REQ-002 Parameter CNT_W, default 8, width of the accepted-press counter.
REQ-003 clk_i  input  1  single system clock; all state SHALL be updated on its rising edge.
REQ-004 rst_i  input  1  synchronous, active-high reset.
REQ-005 btn_i  input  1  raw asynchronous push-button level, 1 = pressed.
REQ-006 irq_ack_i  input  1  interrupt acknowledge from the CPU side, sampled each cycle.
REQ-007 overrun_clr_i  input  1  clears the sticky overrun flag.
REQ-008 btn_state_o  output  1  debounced button level.
REQ-009 irq_req_o  output  1  level interrupt request, held until acknowledged.
REQ-010 overrun_o  output  1  sticky flag: a press arrived while a request was still pending.
REQ-011 press_cnt_o  output  CNT_W  count of accepted presses.

Function
REQ-012 btn_i SHALL pass through a 2-flop synchronizer; only the second flop output (sync) SHALL feed further logic.
REQ-013 Debounce counter width SHALL be $clog2(DEBOUNCE_CYCLES).
REQ-014 Debounce counter behaviour: sync == btn_state_o -> clear to 0; otherwise increment by 1 per cycle.
REQ-015 Level acceptance: when sync != btn_state_o and counter == DEBOUNCE_CYCLES-1, btn_state_o SHALL take sync at that edge and counter SHALL clear.
REQ-016 Glitch rejection: a mismatch that lasts fewer than DEBOUNCE_CYCLES consecutive cycles SHALL leave btn_state_o unchanged.
REQ-017 Press latency: a clean btn_i 0->1 step SHALL raise btn_state_o 2+DEBOUNCE_CYCLES cycles after the first edge sampling btn_i = 1.
REQ-018 Press event: a press SHALL be the cycle in which btn_state_o transitions 0->1; a 1->0 transition SHALL NOT be an event.
REQ-019 Request FSM states: IDLE (irq_req_o = 0) and PENDING (irq_req_o = 1).
REQ-020 IDLE + press event -> PENDING; irq_req_o and btn_state_o SHALL rise on the same edge; press_cnt_o SHALL increment.
REQ-021 PENDING + irq_ack_i and no press event -> IDLE; irq_req_o SHALL fall on the next edge.
REQ-022 PENDING + press event and no irq_ack_i -> remain PENDING; overrun_o SHALL set; press_cnt_o SHALL NOT increment.
REQ-023 PENDING + irq_ack_i + press event in the same cycle -> remain PENDING; the new press is accepted, press_cnt_o SHALL increment, overrun_o SHALL NOT set.
REQ-024 irq_ack_i in IDLE SHALL be ignored.
REQ-025 press_cnt_o SHALL wrap from 2^CNT_W-1 to 0 without side effects.
REQ-026 overrun_o SHALL clear on overrun_clr_i; simultaneous set and clear -> set wins.
REQ-027 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-028 While rst_i = 1 at a clock edge: synchronizer flops, debounce counter, btn_state_o, irq_req_o, overrun_o and press_cnt_o SHALL become 0, and the FSM SHALL enter IDLE.
REQ-029 Reset asserted mid-debounce or in PENDING SHALL discard the partial count and the pending request; no request SHALL be generated on the first cycle after reset even if btn_i = 1.
REQ-030 After reset with btn_i held at 1, the level SHALL be accepted through the normal debounce path (REQ-017) and SHALL generate one press event.

Verification (DEBOUNCE_CYCLES = 4, CNT_W = 8)
REQ-031 Clean press: btn_i 0->1, held -> btn_state_o = 1 and irq_req_o = 1 on the 6th edge; press_cnt_o = 1.
REQ-032 Glitch: btn_i high for 3 cycles, then low -> btn_state_o, irq_req_o and press_cnt_o all stay 0.
REQ-033 Acknowledge: in PENDING, pulse irq_ack_i for 1 cycle -> irq_req_o = 0 on the next edge; release and re-press -> irq_req_o = 1 again, press_cnt_o = 2.
REQ-034 Overrun: second press without an acknowledge -> overrun_o = 1 and press_cnt_o unchanged; overrun_clr_i pulse -> overrun_o = 0; set and clear in the same cycle -> overrun_o = 1.
REQ-035 Collision: irq_ack_i in the same cycle as a press event -> irq_req_o stays 1, press_cnt_o increments, overrun_o = 0.
REQ-036 Wrap and reset: 256 acknowledged presses -> press_cnt_o = 0; rst_i asserted in PENDING -> all outputs 0 on the next edge.
